// File: rtl/sort_out_serializer_if.sv
// sort_out_serializer_if
//   Bundles the signals between the sorting network, the serializer and the
//   element consumer.
//   slave  : the serializer's view. It receives the in_* vector and out_ready,
//            and drives the element stream and the status flags.
//   master : the environment's view, with every direction reversed.
//   Signals:
//     in_valid/in_data/in_label                    sorted vector and its one-cycle strobe
//     out_valid/out_ready                          element handshake
//     out_data/out_label/out_index/out_last        current element
//     busy/overflow                                status flags
interface sort_out_serializer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int LABEL_WIDTH = 2,
  parameter int NUM_INPUTS  = 4
);
  localparam int IDX_W = $clog2(NUM_INPUTS);

  logic                              in_valid;
  logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_data;
  logic [NUM_INPUTS*LABEL_WIDTH-1:0] in_label;
  logic                              out_valid;
  logic                              out_ready;
  logic [DATA_WIDTH-1:0]             out_data;
  logic [LABEL_WIDTH-1:0]            out_label;
  logic [IDX_W-1:0]                  out_index;
  logic                              out_last;
  logic                              busy;
  logic                              overflow;

  modport slave (
    input  in_valid, in_data, in_label, out_ready,
    output out_valid, out_data, out_label, out_index, out_last, busy, overflow
  );

  modport master (
    output in_valid, in_data, in_label, out_ready,
    input  out_valid, out_data, out_label, out_index, out_last, busy, overflow
  );
endinterface

// File: rtl/sort_out_serializer.sv
// sort_out_serializer
//   Takes one sorted vector (data plus labels) from the sorting network on its
//   single-cycle valid pulse. It then streams the elements out one per
//   valid/ready transfer. The network cannot be stalled, so the block has two
//   slots: the active slot, which is streaming, and the pending slot, which is
//   queued. A vector that arrives while both slots are full is dropped, and the
//   sticky overflow flag is set.
//   Ports:
//     clk, rst   clock and synchronous active-high reset
//     bus        sort_out_serializer_if.slave (in_* vector, element stream, busy, overflow)
//     drop_count 16-bit count of dropped vectors, saturating. This port exists
//                only when SORT_OUT_SERIALIZER_DROP_CNT_EN is defined.
//   All outputs are decoded from registered state only.
module sort_out_serializer #(
  parameter int DATA_WIDTH  = 8,
  parameter int LABEL_WIDTH = 2,
  parameter int NUM_INPUTS  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  sort_out_serializer_if.slave   bus
`ifdef SORT_OUT_SERIALIZER_DROP_CNT_EN
  ,
  output logic [15:0]            drop_count
`endif
);
  localparam int IDX_W = $clog2(NUM_INPUTS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_INPUTS - 1);

  logic [DATA_WIDTH-1:0]  act_data_q  [NUM_INPUTS];
  logic [DATA_WIDTH-1:0]  act_data_d  [NUM_INPUTS];
  logic [LABEL_WIDTH-1:0] act_label_q [NUM_INPUTS];
  logic [LABEL_WIDTH-1:0] act_label_d [NUM_INPUTS];
  logic [DATA_WIDTH-1:0]  pend_data_q [NUM_INPUTS];
  logic [DATA_WIDTH-1:0]  pend_data_d [NUM_INPUTS];
  logic [LABEL_WIDTH-1:0] pend_label_q[NUM_INPUTS];
  logic [LABEL_WIDTH-1:0] pend_label_d[NUM_INPUTS];
  logic                   act_full_q, act_full_d;
  logic                   pend_full_q, pend_full_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   overflow_q, overflow_d;
  logic                   drop;

  logic [DATA_WIDTH-1:0]  in_data_v [NUM_INPUTS];
  logic [LABEL_WIDTH-1:0] in_label_v[NUM_INPUTS];

  logic xfer;
  logic retire;
  logic act_free;

  always_comb begin
    for (int k = 0; k < NUM_INPUTS; k++) begin
      in_data_v[k]  = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
      in_label_v[k] = bus.in_label[k*LABEL_WIDTH +: LABEL_WIDTH];
    end
  end

  always_comb begin
    act_data_d   = act_data_q;
    act_label_d  = act_label_q;
    pend_data_d  = pend_data_q;
    pend_label_d = pend_label_q;
    act_full_d   = act_full_q;
    pend_full_d  = pend_full_q;
    idx_d        = idx_q;
    overflow_d   = overflow_q;
    drop         = 1'b0;

    xfer     = act_full_q && bus.out_ready;
    retire   = xfer && (idx_q == IDX_LAST);
    // Retiring frees the active slot in the same cycle, so a simultaneous
    // input can be taken without a bubble.
    act_free = !act_full_q || retire;

    if (xfer) begin
      idx_d = retire ? '0 : idx_q + IDX_W'(1);
    end

    if (bus.in_valid) begin
      if (act_free && !pend_full_q) begin
        act_data_d  = in_data_v;
        act_label_d = in_label_v;
        act_full_d  = 1'b1;
        idx_d       = '0;
      end else if (act_free) begin
        act_data_d   = pend_data_q;
        act_label_d  = pend_label_q;
        pend_data_d  = in_data_v;
        pend_label_d = in_label_v;
        act_full_d   = 1'b1;
        pend_full_d  = 1'b1;
        idx_d        = '0;
      end else if (!pend_full_q) begin
        pend_data_d  = in_data_v;
        pend_label_d = in_label_v;
        pend_full_d  = 1'b1;
      end else begin
        overflow_d = 1'b1;
        drop       = 1'b1;
      end
    end else if (retire) begin
      if (pend_full_q) begin
        act_data_d  = pend_data_q;
        act_label_d = pend_label_q;
        pend_full_d = 1'b0;
      end else begin
        act_full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        act_data_q[k]   <= '0;
        act_label_q[k]  <= '0;
        pend_data_q[k]  <= '0;
        pend_label_q[k] <= '0;
      end
      act_full_q  <= 1'b0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      act_data_q   <= act_data_d;
      act_label_q  <= act_label_d;
      pend_data_q  <= pend_data_d;
      pend_label_q <= pend_label_d;
      act_full_q   <= act_full_d;
      pend_full_q  <= pend_full_d;
      idx_q        <= idx_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef SORT_OUT_SERIALIZER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  assign bus.out_valid = act_full_q;
  assign bus.busy      = act_full_q;
  assign bus.out_data  = act_data_q[idx_q];
  assign bus.out_label = act_label_q[idx_q];
  assign bus.out_index = idx_q;
  assign bus.out_last  = act_full_q && (idx_q == IDX_LAST);
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_sort_out_serializer.sv
module tb_sort_out_serializer;
  localparam int DW = 8;
  localparam int LW = 2;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sort_out_serializer_if #(.DATA_WIDTH(DW), .LABEL_WIDTH(LW), .NUM_INPUTS(N)) bus ();

`ifdef SORT_OUT_SERIALIZER_DROP_CNT_EN
  logic [15:0] drop_count;
  sort_out_serializer #(.DATA_WIDTH(DW), .LABEL_WIDTH(LW), .NUM_INPUTS(N)) dut (
    .clk(clk), .rst(rst), .bus(bus), .drop_count(drop_count));
`else
  sort_out_serializer #(.DATA_WIDTH(DW), .LABEL_WIDTH(LW), .NUM_INPUTS(N)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue holding at most two whole vectors, plus the
  // position reached in the front vector.
  typedef struct packed {
    logic [N*DW-1:0] d;
    logic [N*LW-1:0] l;
  } vec_t;

  vec_t m_q[$];
  int   m_idx     = 0;
  bit   m_ovf     = 0;
  int   m_drops   = 0;
  bit   m_fresh   = 0;
  bit   m_started = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_idx     = 0;
      m_ovf     = 0;
      m_drops   = 0;
      m_fresh   = 1;
      m_started = 1;
    end else begin
      m_fresh = 0;
      if (m_q.size() > 0 && bus.out_ready) begin
        if (m_idx == N - 1) begin
          void'(m_q.pop_front());
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (bus.in_valid) begin
        if (m_q.size() < 2) begin
          m_q.push_back('{d: bus.in_data, l: bus.in_label});
        end else begin
          m_ovf = 1;
          if (m_drops < 16'hFFFF) m_drops++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
      check("busy", 32'(bus.busy), 32'(m_q.size() > 0));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("out_index", 32'(bus.out_index), 32'(m_idx));
      check("out_last", 32'(bus.out_last), 32'((m_q.size() > 0) && (m_idx == N - 1)));
      if (m_q.size() > 0) begin
        check("out_data", 32'(bus.out_data), 32'(m_q[0].d[m_idx*DW +: DW]));
        check("out_label", 32'(bus.out_label), 32'(m_q[0].l[m_idx*LW +: LW]));
      end
      if (m_fresh) begin
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_label", 32'(bus.out_label), 32'd0);
      end
`ifdef SORT_OUT_SERIALIZER_DROP_CNT_EN
      check("drop_count", 32'(drop_count), 32'(m_drops));
`endif
    end
  end

  function automatic logic [N*DW-1:0] mk_data(input int a, input int b, input int c, input int d);
    return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
  endfunction

  task automatic send(input logic [N*DW-1:0] d, input logic [N*LW-1:0] l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_label = l;
  endtask

  logic [N*DW-1:0] vd;
  logic [N*LW-1:0] vl;
  int exp_d[7] = '{3, 7, 7, 7, 9, 12, 12};
  int bp_rdy[7] = '{1, 0, 0, 1, 1, 0, 1};
  int sv_d[4] = '{3, 7, 9, 12};
  int sv_l[4] = '{2, 0, 3, 1};

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_label  = '0;
    bus.out_ready = 1'b0;
    vd = mk_data(3, 7, 9, 12);
    vl = {2'd1, 2'd3, 2'd0, 2'd2};
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single vector
    bus.out_ready = 1'b1;
    check("sv_valid_before", 32'(bus.out_valid), 32'd0);
    send(vd, vl);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("sv_valid", 32'(bus.out_valid), 32'd1);
      check("sv_data", 32'(bus.out_data), 32'(sv_d[k]));
      check("sv_label", 32'(bus.out_label), 32'(sv_l[k]));
      check("sv_index", 32'(bus.out_index), 32'(k));
      check("sv_last", 32'(bus.out_last), 32'(k == 3));
      @(negedge clk);
    end
    check("sv_valid_after", 32'(bus.out_valid), 32'd0);

    // Backpressure
    send(vd, vl);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus.out_ready = bp_rdy[k][0];
      check("bp_data", 32'(bus.out_data), 32'(exp_d[k]));
      @(negedge clk);
    end
    check("bp_done", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;

    // Back-to-back
    send(mk_data(1, 2, 3, 4), '0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("b2b_valid", 32'(bus.out_valid), 32'd1);
      check("b2b_data", 32'(bus.out_data), 32'(c + 1));
      if (c == 1) send(mk_data(5, 6, 7, 8), '1);
      else bus.in_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_ovf", 32'(bus.overflow), 32'd0);
    check("b2b_end", 32'(bus.out_valid), 32'd0);

    // Retire and input in the same cycle
    send(mk_data(10, 11, 12, 13), '0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rt_last", 32'(bus.out_last), 32'd1);
    send(mk_data(20, 21, 22, 23), '1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rt_data", 32'(bus.out_data), 32'd20);
    check("rt_index", 32'(bus.out_index), 32'd0);
    check("rt_ovf", 32'(bus.overflow), 32'd0);
    repeat (4) @(negedge clk);

    // Overflow
    bus.out_ready = 1'b0;
    send(mk_data(31, 32, 33, 34), '0);
    @(negedge clk);
    send(mk_data(41, 42, 43, 44), '0);
    @(negedge clk);
    send(mk_data(51, 52, 53, 54), '0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("ov_flag", 32'(bus.overflow), 32'd1);
`ifdef SORT_OUT_SERIALIZER_DROP_CNT_EN
    check("ov_drop_count", 32'(drop_count), 32'd1);
`endif
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      check("ov_data", 32'(bus.out_data), 32'(c < 4 ? 31 + c : 37 + c));
      @(negedge clk);
    end
    check("ov_end", 32'(bus.out_valid), 32'd0);

    // Mid-stream reset
    send(mk_data(61, 62, 63, 64), '0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mr_idx", 32'(bus.out_index), 32'd2);
    rst = 1'b1;
    send(mk_data(71, 72, 73, 74), '0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("mr_valid", 32'(bus.out_valid), 32'd0);
    check("mr_busy", 32'(bus.busy), 32'd0);
    check("mr_ovf", 32'(bus.overflow), 32'd0);
    check("mr_data", 32'(bus.out_data), 32'd0);
    send(mk_data(81, 82, 83, 84), '0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mr_fresh_data", 32'(bus.out_data), 32'd81);
    check("mr_fresh_index", 32'(bus.out_index), 32'd0);
    repeat (4) @(negedge clk);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(0, 399) == 0);
      bus.in_valid  = ($urandom_range(0, 3) == 0);
      bus.in_data   = $urandom;
      bus.in_label  = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sort_out_serializer.md
Name: sort_out_serializer

Overview:
- Downstream stage of the non-recursive sorting network.
- Captures one sorted parallel vector (data plus labels) on the network's single-cycle valid pulse, and streams the elements out one per transfer over a valid/ready interface.
- The sorting network has no backpressure, so the block holds two vectors (active + pending) and flags any vector it has to drop.

Parameters:
- DATA_WIDTH, 8, width of one data element
- LABEL_WIDTH, 2, width of one label
- NUM_INPUTS, 4, elements per vector; must be ≥2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  one-cycle pulse; sorted vector present on in_data/in_label
- in_data  in  NUM_INPUTS*DATA_WIDTH  element k at bits [k*DATA_WIDTH +: DATA_WIDTH]; k=0 is the network's y_0
- in_label  in  NUM_INPUTS*LABEL_WIDTH  label k at bits [k*LABEL_WIDTH +: LABEL_WIDTH]
- out_valid  out  1  current element valid
- out_ready  in  1  consumer accepts element
- out_data  out  DATA_WIDTH  current element
- out_label  out  LABEL_WIDTH  current label
- out_index  out  $clog2(NUM_INPUTS)  position of current element within its vector
- out_last  out  1  high with out_valid when out_index==NUM_INPUTS-1
- busy  out  1  active slot full
- overflow  out  1  sticky; a vector was dropped

Behaviour:
- State: active slot (vector + full flag), pending slot (vector + full flag), index counter idx.
- Outputs derive from registered state only; no combinational path from in_* or out_ready to any output.
- Output mapping: out_valid = active_full; out_data/out_label = active element idx; out_index = idx; busy = active_full.
- Reset: both slots empty and cleared to 0, idx=0. out_valid=0, out_data=0, out_label=0, out_index=0, out_last=0, busy=0, overflow=0.
- Transfer: occurs when out_valid && out_ready, and advances idx by 1.
  - Hold stability: while out_valid && !out_ready, out_data, out_label and out_index hold stable.
  - Last transfer: a transfer at idx==NUM_INPUTS-1. The active slot retires and idx wraps to 0.
- Input handling, one cycle, evaluated after accounting for a retire in the same cycle:
  - Active empty (or retiring), pending empty: load in_* into active. out_valid rises the next cycle with element 0. Latency is 1 cycle from in_valid.
  - Active retiring, pending full: pending moves to active and input moves to pending, with no bubble.
  - Active full and not retiring, pending empty: load input into pending.
  - Active full and not retiring, pending full: drop input and set overflow. Slots are unchanged.
- Retire with pending full and no input: pending moves to active and idx=0. The next cycle presents pending element 0, so streaming is back-to-back.
- Retire with pending empty and no input: active becomes empty and out_valid falls the next cycle.
- Throughput: with out_ready held high, NUM_INPUTS cycles per vector, no idle cycles between queued vectors.
- Overflow clears only on rst.
- Reset mid-stream: rst takes priority over all events. The next cycle shows the reset values, and an in_valid during the rst cycle is ignored.
- Labels are passed through unmodified.

Optional Feature:
- Macro: SORT_OUT_SERIALIZER_DROP_CNT_EN.
- Defined: adds output port drop_count (16 bits), the number of dropped vectors.
  - Saturates at 16'hFFFF.
  - Increments in the same cycle overflow is set by a drop.
  - Resets to 0.
- Undefined: the port and counter are absent; overflow behaviour is unchanged.

Test Plan:
- Single vector: rst, then in_valid with data {y0..y3}={3,7,9,12}, labels {2,0,3,1}, out_ready=1.
  - out_valid rises the cycle after in_valid.
  - Stream is (3,2,0),(7,0,1),(9,3,2),(12,1,3) as (data,label,index) on 4 consecutive cycles, out_last on the 4th.
  - out_valid then falls.
- Backpressure: same vector, out_ready toggled 1,0,0,1,1,0,1.
  - Elements are emitted in order only on ready cycles.
  - Outputs are held during stall cycles.
  - 4 transfers total.
- Back-to-back: vector A {1,2,3,4} then vector B {5,6,7,8} two cycles later, out_ready=1.
  - Output is 1..8 on 8 consecutive cycles, no gap.
  - overflow=0.
- Overflow: out_ready=0, three in_valid pulses with A, B, C.
  - overflow=1 after the third pulse.
  - Releasing ready streams A then B only.
  - drop_count=1 when the macro is defined.
- Retire and input in the same cycle: pending empty, in_valid on the cycle of A's last transfer.
  - New vector element 0 appears the next cycle.
  - overflow=0.
- Mid-stream reset: assert rst at A's idx=2.
  - Next cycle out_valid=0, busy=0, overflow=0, out_data=0.
  - A fresh vector afterwards streams from index 0.
